serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 119 +++++++++++
 tb/tb_serial_subtractor.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock through a
// single full-subtractor cell and a borrow flip-flop, with a start/busy/done handshake.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-2:0] res_q, res_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic             d_bit;
    logic             borrow_nxt;
    logic [WIDTH-1:0] res_shift;

    // Full-subtractor cell on the current LSBs.
    assign d_bit      = a_sr_q[0] ^ b_sr_q[0] ^ borrow_q;
    assign borrow_nxt = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & borrow_q);
    assign res_shift  = {d_bit, res_q};

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            StIdle: begin
                state_d = StIdle;
            end
            StRun: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                res_d    = res_shift[WIDTH-1:1];
                borrow_d = borrow_nxt;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    diff_d  = res_shift;
                    bout_d  = borrow_nxt;
                    ovf_d   = borrow_q ^ borrow_nxt;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Accept a start from IDLE or on the DONE exit edge; ignored while running.
        if (start && (state_q != StRun)) begin
            a_sr_d   = a;
            b_sr_d   = b;
            borrow_d = bin;
            cnt_d    = '0;
            state_d  = StRun;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table, handshake corner cases,
// random ops against an integer reference model, and an exhaustive WIDTH=2 sweep.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0, bin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, bout8, ovf8;
    logic [7:0] diff8;

    logic       start2 = 1'b0, bin2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0;
    logic       busy2, done2, bout2, ovf2;
    logic [1:0] diff2;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
    );

    serial_subtractor #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .bin(bin2),
        .busy(busy2), .done(done2), .diff(diff2), .bout(bout2), .ovf(ovf2)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] diff;
        logic       bout;
        logic       ovf;
    } vec_t;

    vec_t tbl[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic void model(input int w, input int ia, input int ib, input int ibin,
                                  output int d, output int bo, output int ov);
        int m, r, sa, sb, s;
        m  = 1 << w;
        r  = ia - ib - ibin;
        bo = (r < 0) ? 1 : 0;
        d  = (r + m) % m;
        sa = (ia >= m / 2) ? ia - m : ia;
        sb = (ib >= m / 2) ? ib - m : ib;
        s  = sa - sb - ibin;
        ov = ((s < -(m / 2)) || (s >= m / 2)) ? 1 : 0;
    endfunction

    // Issues one start on dut8; returns in the done cycle (or after the bound).
    task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                       output int lat, output int busyc);
        a8 = ia; b8 = ib; bin8 = ibin; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        lat = 0; busyc = 0;
        while (!done8 && lat < 40) begin
            if (busy8) busyc++;
            tick();
            lat++;
        end
    endtask

    task automatic op2(input logic [1:0] ia, input logic [1:0] ib, input logic ibin,
                       output int lat);
        a2 = ia; b2 = ib; bin2 = ibin; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        lat = 0;
        while (!done2 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat, busyc, ed, ebo, eov, seen;

        tbl[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        tbl[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
        tbl[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        tbl[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        tbl[5] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0};
        tbl[6] = '{8'h20, 8'h20, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[7] = '{8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1};

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_diff", diff8, 0);
        chk("rst_bout", bout8, 0);
        chk("rst_ovf", ovf8, 0);

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            op8(tbl[i].a, tbl[i].b, tbl[i].bin, lat, busyc);
            chk($sformatf("tbl%0d_lat", i), lat, 8);
            chk($sformatf("tbl%0d_busy", i), busyc, 8);
            chk($sformatf("tbl%0d_diff", i), diff8, tbl[i].diff);
            chk($sformatf("tbl%0d_bout", i), bout8, tbl[i].bout);
            chk($sformatf("tbl%0d_ovf", i), ovf8, tbl[i].ovf);
            tick();
            chk($sformatf("tbl%0d_done_pulse", i), done8, 0);
            chk($sformatf("tbl%0d_hold", i), diff8, tbl[i].diff);
        end

        // Start during RUN is ignored; start held through DONE exit chains a second op
        a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 40) begin
            tick();
            lat++;
        end
        chk("busy_start_lat", lat, 5);
        chk("busy_start_diff", diff8, 8'h0F);
        a8 = 8'h20; b8 = 8'h20; start8 = 1'b1;
        tick();
        chk("b2b_busy", busy8, 1);
        start8 = 1'b0;
        lat = 1;
        while (!done8 && lat < 40) begin
            tick();
            lat++;
        end
        chk("b2b_lat", lat, 9);
        chk("b2b_diff", diff8, 8'h00);
        tick();

        // Reset mid-operation
        op8(8'h05, 8'h03, 1'b0, lat, busyc);
        chk("pre_rst_diff", diff8, 8'h02);
        tick();
        a8 = 8'h09; b8 = 8'h01; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        tick();
        chk("run_keeps_diff", diff8, 8'h02);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", busy8, 0);
        chk("midrst_done", done8, 0);
        chk("midrst_diff", diff8, 0);
        chk("midrst_bout", bout8, 0);
        chk("midrst_ovf", ovf8, 0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8 || busy8) seen = 1;
            tick();
        end
        chk("midrst_no_done", seen, 0);
        op8(8'h09, 8'h01, 1'b0, lat, busyc);
        chk("after_rst_lat", lat, 8);
        chk("after_rst_diff", diff8, 8'h08);
        tick();

        // Random operations, sometimes back to back from the DONE cycle
        for (int i = 0; i < 150; i++) begin
            logic [7:0] ra, rb;
            logic       rbin;
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rbin = 1'($urandom);
            op8(ra, rb, rbin, lat, busyc);
            model(8, int'(ra), int'(rb), int'(rbin), ed, ebo, eov);
            chk($sformatf("rnd%0d_lat", i), lat, 8);
            chk($sformatf("rnd%0d_diff", i), diff8, ed);
            chk($sformatf("rnd%0d_bout", i), bout8, ebo);
            chk($sformatf("rnd%0d_ovf", i), ovf8, eov);
            if ($urandom_range(1, 0) == 0) tick();
        end
        tick();

        // Exhaustive WIDTH=2
        for (int ia = 0; ia < 4; ia++) begin
            for (int ib = 0; ib < 4; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    op2(2'(ia), 2'(ib), 1'(ic), lat);
                    model(2, ia, ib, ic, ed, ebo, eov);
                    chk($sformatf("w2_%0d_%0d_%0d_lat", ia, ib, ic), lat, 2);
                    chk($sformatf("w2_%0d_%0d_%0d_diff", ia, ib, ic), diff2, ed);
                    chk($sformatf("w2_%0d_%0d_%0d_bout", ia, ib, ic), bout2, ebo);
                    chk($sformatf("w2_%0d_%0d_%0d_ovf", ia, ib, ic), ovf2, eov);
                    tick();
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
